// File: rtl/text_buffer_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : text_buffer_ctrl_pkg
//  Description : Shared constants, control codes and FSM encoding for the
//                text buffer controller.
//  Revision    : 1.0  initial release
// ============================================================================
package text_buffer_ctrl_pkg;

    localparam int DEF_COLS = 32;
    localparam int DEF_ROWS = 4;

    localparam logic [7:0] CC_BS  = 8'h08;
    localparam logic [7:0] CC_LF  = 8'h0A;
    localparam logic [7:0] CC_FF  = 8'h0C;
    localparam logic [7:0] CC_CR  = 8'h0D;
    localparam logic [7:0] CC_DEL = 8'h7F;
    localparam logic [7:0] SPACE  = 8'h20;

    typedef enum logic [2:0] {
        S_CLEAR     = 3'd0,
        S_IDLE      = 3'd1,
        S_SCROLL_RD = 3'd2,
        S_SCROLL_WR = 3'd3,
        S_FILL      = 3'd4
    } state_t;

    // Printable ASCII plus the whole upper half (Thai bank) is stored verbatim.
    function automatic logic is_glyph(input logic [7:0] b);
        return (b >= SPACE) && (b != CC_DEL);
    endfunction

endpackage
`default_nettype wire

// File: rtl/text_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : text_buffer_ctrl_if
//  Description : Valid/ready byte stream into the text buffer controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface text_buffer_ctrl_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (output wr_valid, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_data, output wr_ready);
endinterface
`default_nettype wire

// File: rtl/text_buffer_ctrl_ram.sv
`default_nettype none
// ============================================================================
//  Module      : text_buffer_ctrl_ram
//  Description : Simple dual-port 8-bit text RAM; port A read/write for the
//                FSM, port B read-only for the display path.
//  Revision    : 1.0  initial release
// ============================================================================
module text_buffer_ctrl_ram #(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_wdata,
    output logic [7:0]    a_rdata,
    input  logic [AW-1:0] b_addr,
    output logic [7:0]    b_rdata
);
    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (a_we) begin
            r_mem[a_addr] <= a_wdata;
        end
        a_rdata <= r_mem[a_addr];
    end

    always_ff @(posedge clk) begin
        b_rdata <= r_mem[b_addr];
    end
endmodule
`default_nettype wire

// File: rtl/text_buffer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : text_buffer_ctrl
//  Description : Character buffer controller: cursor, wrap, control codes,
//                clear/scroll sequencing and per-pixel glyph lookup.
//  Revision    : 1.0  initial release
// ============================================================================
module text_buffer_ctrl
    import text_buffer_ctrl_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int X0   = 192,
    parameter int Y0   = 208
) (
    input  logic                    clk,
    input  logic                    reset_n,
    text_buffer_ctrl_if.slave       wr,
    input  logic [9:0]              x,
    input  logic [9:0]              y,
    output logic [7:0]              ascii_code,
    output logic [$clog2(COLS)-1:0] cursor_col,
    output logic [$clog2(ROWS)-1:0] cursor_row,
    output logic                    busy
);
    localparam int CELLS = COLS * ROWS;
    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int AW    = $clog2(CELLS);

    localparam logic [AW-1:0] c_LAST_CELL   = AW'(CELLS - 1);
    localparam logic [AW-1:0] c_LAST_SCROLL = AW'(COLS * (ROWS - 1) - 1);
    localparam logic [AW-1:0] c_ROW_STRIDE  = AW'(COLS);
    localparam logic [CW-1:0] c_LAST_COL    = CW'(COLS - 1);
    localparam logic [RW-1:0] c_LAST_ROW    = RW'(ROWS - 1);
    localparam logic [10:0]   c_X_LO        = 11'(X0);
    localparam logic [10:0]   c_X_HI        = 11'(X0 + 8 * COLS);
    localparam logic [10:0]   c_Y_LO        = 11'(Y0);
    localparam logic [10:0]   c_Y_HI        = 11'(Y0 + 16 * ROWS);

    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_idx, w_idx_nxt;
    logic [CW-1:0] r_col, w_col_nxt;
    logic [RW-1:0] r_row, w_row_nxt;
    logic          w_fire, w_newline;
    logic          w_a_we;
    logic [AW-1:0] w_a_addr, w_cur_addr, w_disp_addr;
    logic [7:0]    w_a_wdata, w_a_rdata, w_b_rdata;
    logic          w_in_win, r_in_win;

    assign wr.wr_ready = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign w_fire      = wr.wr_valid && (r_state == S_IDLE);
    assign w_cur_addr  = AW'(r_row) * c_ROW_STRIDE + AW'(r_col);
    assign cursor_col  = r_col;
    assign cursor_row  = r_row;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_CLEAR;
            r_idx    <= '0;
            r_col    <= '0;
            r_row    <= '0;
            r_in_win <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_idx    <= w_idx_nxt;
            r_col    <= w_col_nxt;
            r_row    <= w_row_nxt;
            r_in_win <= w_in_win;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_a_we      = 1'b0;
        w_a_addr    = r_idx;
        w_a_wdata   = SPACE;
        w_newline   = 1'b0;
        case (r_state)
            S_CLEAR: begin
                w_a_we = 1'b1;
                if (r_idx == c_LAST_CELL) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                    w_col_nxt   = '0;
                    w_row_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
            S_IDLE: begin
                if (w_fire) begin
                    if (wr.wr_data == CC_FF) begin
                        w_state_nxt = S_CLEAR;
                        w_idx_nxt   = '0;
                        w_col_nxt   = '0;
                        w_row_nxt   = '0;
                    end else if (wr.wr_data == CC_CR || wr.wr_data == CC_LF) begin
                        w_newline = 1'b1;
                    end else if (wr.wr_data == CC_BS) begin
                        // Both backspace cases land on the cell just before the cursor.
                        if (r_col != '0 || r_row != '0) begin
                            w_a_we   = 1'b1;
                            w_a_addr = w_cur_addr - AW'(1);
                            if (r_col != '0) begin
                                w_col_nxt = r_col - CW'(1);
                            end else begin
                                w_col_nxt = c_LAST_COL;
                                w_row_nxt = r_row - RW'(1);
                            end
                        end
                    end else if (is_glyph(wr.wr_data)) begin
                        w_a_we    = 1'b1;
                        w_a_addr  = w_cur_addr;
                        w_a_wdata = wr.wr_data;
                        if (r_col == c_LAST_COL) begin
                            w_newline = 1'b1;
                        end else begin
                            w_col_nxt = r_col + CW'(1);
                        end
                    end
                    if (w_newline) begin
                        w_col_nxt = '0;
                        if (r_row == c_LAST_ROW) begin
                            w_state_nxt = S_SCROLL_RD;
                            w_idx_nxt   = '0;
                        end else begin
                            w_row_nxt = r_row + RW'(1);
                        end
                    end
                end
            end
            S_SCROLL_RD: begin
                w_a_addr    = r_idx + c_ROW_STRIDE;
                w_state_nxt = S_SCROLL_WR;
            end
            S_SCROLL_WR: begin
                // Index runs straight on into the last row, where FILL starts.
                w_a_we      = 1'b1;
                w_a_wdata   = w_a_rdata;
                w_idx_nxt   = r_idx + AW'(1);
                w_state_nxt = (r_idx == c_LAST_SCROLL) ? S_FILL : S_SCROLL_RD;
            end
            S_FILL: begin
                w_a_we = 1'b1;
                if (r_idx == c_LAST_CELL) begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = '0;
                end else begin
                    w_idx_nxt = r_idx + AW'(1);
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_idx_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_in_win    = ({1'b0, x} >= c_X_LO) && ({1'b0, x} < c_X_HI) &&
                      ({1'b0, y} >= c_Y_LO) && ({1'b0, y} < c_Y_HI);
        w_disp_addr = AW'(RW'(({1'b0, y} - c_Y_LO) >> 4)) * c_ROW_STRIDE +
                      AW'(CW'(({1'b0, x} - c_X_LO) >> 3));
    end

    // The in-window flag is registered alongside the RAM read so both line up.
    assign ascii_code = r_in_win ? w_b_rdata : SPACE;

    text_buffer_ctrl_ram #(
        .DEPTH (CELLS),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .a_we    (w_a_we),
        .a_addr  (w_a_addr),
        .a_wdata (w_a_wdata),
        .a_rdata (w_a_rdata),
        .b_addr  (w_disp_addr),
        .b_rdata (w_b_rdata)
    );
endmodule
`default_nettype wire

// File: tb/tb_text_buffer_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_text_buffer_ctrl
//  Description : Self-checking bench with a screen-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_text_buffer_ctrl;
    localparam int COLS       = 32;
    localparam int ROWS       = 4;
    localparam int CELLS      = COLS * ROWS;
    localparam int X0         = 192;
    localparam int Y0         = 208;
    localparam int SCROLL_CYC = 2 * COLS * (ROWS - 1) + COLS;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [9:0] x, y;
    logic [7:0] ascii_code;
    logic [4:0] cursor_col;
    logic [1:0] cursor_row;
    logic       busy;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] m_mem [CELLS];
    int         m_col, m_row;
    logic [7:0] got [CELLS];

    text_buffer_ctrl_if wr_if();

    text_buffer_ctrl #(.COLS(COLS), .ROWS(ROWS), .X0(X0), .Y0(Y0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr         (wr_if),
        .x          (x),
        .y          (y),
        .ascii_code (ascii_code),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        for (int i = 0; i < CELLS; i++) m_mem[i] = 8'h20;
        m_col = 0;
        m_row = 0;
    endfunction

    // Returns the number of cycles the controller should stay busy afterwards.
    function automatic int model_apply(input logic [7:0] b);
        bit nl = 0;
        int cyc = 0;
        if (b == 8'h0C) begin
            model_reset();
            return CELLS;
        end
        if (b == 8'h0D || b == 8'h0A) begin
            nl = 1;
        end else if (b == 8'h08) begin
            if (m_col > 0) begin
                m_col--;
                m_mem[m_row * COLS + m_col] = 8'h20;
            end else if (m_row > 0) begin
                m_row--;
                m_col = COLS - 1;
                m_mem[m_row * COLS + m_col] = 8'h20;
            end
        end else if (b >= 8'h20 && b != 8'h7F) begin
            m_mem[m_row * COLS + m_col] = b;
            if (m_col == COLS - 1) nl = 1;
            else m_col++;
        end
        if (nl) begin
            m_col = 0;
            if (m_row == ROWS - 1) begin
                for (int r = 0; r < ROWS - 1; r++)
                    for (int c = 0; c < COLS; c++)
                        m_mem[r * COLS + c] = m_mem[(r + 1) * COLS + c];
                for (int c = 0; c < COLS; c++) m_mem[(ROWS - 1) * COLS + c] = 8'h20;
                cyc = SCROLL_CYC;
            end else begin
                m_row++;
            end
        end
        return cyc;
    endfunction

    function automatic logic [7:0] rand_glyph();
        logic [7:0] v;
        v = 8'($urandom_range(32, 255));
        if (v == 8'h7F) v = 8'h41;
        return v;
    endfunction

    // All tasks start and end 1 ns after a rising edge.
    task automatic send_byte(input logic [7:0] b, output int exp_busy);
        int n;
        n = 0;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = b;
        while (wr_if.wr_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        wr_if.wr_valid = 1'b0;
        exp_busy = model_apply(b);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (wr_if.wr_ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic read_cell(input int i, output logic [7:0] v);
        x = 10'(X0 + 8 * (i % COLS) + int'($urandom_range(0, 7)));
        y = 10'(Y0 + 16 * (i / COLS) + int'($urandom_range(0, 15)));
        @(posedge clk); #1;
        v = ascii_code;
    endtask

    task automatic read_screen();
        for (int i = 0; i < CELLS; i++) read_cell(i, got[i]);
    endtask

    task automatic test_reset();
        int n;
        reset_n = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_data  = 8'h00;
        x = '0;
        y = '0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (ascii_code !== 8'h20) $display("FAIL reset_ascii: got %h want 20", ascii_code); else n_pass++;
        n_chk++; if (cursor_col !== 5'd0 || cursor_row !== 2'd0) $display("FAIL reset_cursor: got (%0d,%0d) want (0,0)", cursor_col, cursor_row); else n_pass++;
        n_chk++; if (wr_if.wr_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", wr_if.wr_ready); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
        reset_n = 1'b1;
        model_reset();
        wait_idle(n);
        n_chk++; if (n != CELLS) $display("FAIL clear_len: got %0d cycles want %0d", n, CELLS); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else n_pass++;
        read_screen();
        for (int i = 0; i < CELLS; i++) begin
            n_chk++; if (got[i] !== m_mem[i]) $display("FAIL reset_cell[%0d]: got %h want %h", i, got[i], m_mem[i]); else n_pass++;
        end
    endtask

    task automatic test_single_char();
        int eb;
        send_byte(8'h41, eb);
        n_chk++; if (cursor_col !== 5'd1 || cursor_row !== 2'd0) $display("FAIL char_cursor: got (%0d,%0d) want (1,0)", cursor_col, cursor_row); else n_pass++;
        x = 10'(X0);
        y = 10'(Y0);
        #1;
        n_chk++; if (ascii_code !== 8'h20) $display("FAIL char_latency: got %h want 20 before the edge", ascii_code); else n_pass++;
        @(posedge clk); #1;
        n_chk++; if (ascii_code !== 8'h41) $display("FAIL char_display: got %h want 41", ascii_code); else n_pass++;
        x = 10'(X0 + 7); y = 10'(Y0 + 15);
        @(posedge clk); #1;
        n_chk++; if (ascii_code !== 8'h41) $display("FAIL cell_inner_edge: got %h want 41", ascii_code); else n_pass++;
        x = 10'(X0 - 1); y = 10'(Y0);
        @(posedge clk); #1;
        n_chk++; if (ascii_code !== 8'h20) $display("FAIL win_left: got %h want 20", ascii_code); else n_pass++;
        x = 10'(X0); y = 10'(Y0 - 1);
        @(posedge clk); #1;
        n_chk++; if (ascii_code !== 8'h20) $display("FAIL win_top: got %h want 20", ascii_code); else n_pass++;
        x = 10'(X0 + 8 * COLS); y = 10'(Y0);
        @(posedge clk); #1;
        n_chk++; if (ascii_code !== 8'h20) $display("FAIL win_right: got %h want 20", ascii_code); else n_pass++;
        x = 10'(X0); y = 10'(Y0 + 16 * ROWS);
        @(posedge clk); #1;
        n_chk++; if (ascii_code !== 8'h20) $display("FAIL win_bottom: got %h want 20", ascii_code); else n_pass++;
    endtask

    task automatic test_wrap_cr_bs();
        int eb, n;
        logic [7:0] b, v;
        send_byte(8'h0C, eb);
        wait_idle(n);
        n_chk++; if (n != eb) $display("FAIL ff_len: got %0d want %0d", n, eb); else n_pass++;
        send_byte(8'h08, eb);
        n_chk++; if (cursor_col !== 5'd0 || cursor_row !== 2'd0 || busy !== 1'b0) $display("FAIL bs_home: got (%0d,%0d) busy %b want (0,0) busy 0", cursor_col, cursor_row, busy); else n_pass++;
        b = 8'h00;
        for (int k = 0; k < 33; k++) begin
            b = rand_glyph();
            send_byte(b, eb);
        end
        n_chk++; if (cursor_col !== 5'd1 || cursor_row !== 2'd1) $display("FAIL wrap_cursor: got (%0d,%0d) want (1,1)", cursor_col, cursor_row); else n_pass++;
        read_cell(32, v);
        n_chk++; if (v !== b) $display("FAIL wrap_cell32: got %h want %h", v, b); else n_pass++;
        send_byte(8'h0D, eb);
        n_chk++; if (cursor_col !== 5'd0 || cursor_row !== 2'd2) $display("FAIL cr_cursor: got (%0d,%0d) want (0,2)", cursor_col, cursor_row); else n_pass++;
        send_byte(8'h0C, eb);
        wait_idle(n);
        for (int k = 0; k < 32; k++) send_byte(rand_glyph(), eb);
        send_byte(8'h08, eb);
        n_chk++; if (cursor_col !== 5'd31 || cursor_row !== 2'd0) $display("FAIL bs_row_cursor: got (%0d,%0d) want (31,0)", cursor_col, cursor_row); else n_pass++;
        read_cell(31, v);
        n_chk++; if (v !== 8'h20) $display("FAIL bs_row_cell31: got %h want 20", v); else n_pass++;
    endtask

    task automatic test_scroll();
        int eb, n;
        logic [7:0] sent [CELLS];
        send_byte(8'h0C, eb);
        wait_idle(n);
        for (int k = 0; k < CELLS; k++) begin
            sent[k] = rand_glyph();
            send_byte(sent[k], eb);
            wait_idle(n);
            n_chk++; if (n != eb) $display("FAIL fill_busy[%0d]: got %0d cycles want %0d", k, n, eb); else n_pass++;
        end
        n_chk++; if (cursor_col !== 5'd0 || cursor_row !== 2'd3) $display("FAIL scroll_cursor: got (%0d,%0d) want (0,3)", cursor_col, cursor_row); else n_pass++;
        read_screen();
        for (int c = 0; c < COLS; c++) begin
            n_chk++; if (got[c] !== sent[COLS + c]) $display("FAIL scroll_row0[%0d]: got %h want %h", c, got[c], sent[COLS + c]); else n_pass++;
        end
        for (int i = 0; i < CELLS; i++) begin
            n_chk++; if (got[i] !== m_mem[i]) $display("FAIL scroll_cell[%0d]: got %h want %h", i, got[i], m_mem[i]); else n_pass++;
        end
    endtask

    task automatic test_thai_and_clear();
        int eb, n;
        logic [7:0] v;
        send_byte(8'hA1, eb);
        n_chk++; if (cursor_col !== 5'd1 || cursor_row !== 2'd3) $display("FAIL thai_cursor: got (%0d,%0d) want (1,3)", cursor_col, cursor_row); else n_pass++;
        read_cell(3 * COLS, v);
        n_chk++; if (v !== 8'hA1) $display("FAIL thai_cell: got %h want a1", v); else n_pass++;
        send_byte(8'h7F, eb);
        send_byte(8'h01, eb);
        n_chk++; if (cursor_col !== 5'd1 || cursor_row !== 2'd3 || busy !== 1'b0) $display("FAIL ignored_codes: got (%0d,%0d) busy %b want (1,3) busy 0", cursor_col, cursor_row, busy); else n_pass++;
        send_byte(8'h0C, eb);
        wait_idle(n);
        n_chk++; if (n != CELLS) $display("FAIL ff_clear_len: got %0d want %0d", n, CELLS); else n_pass++;
        n_chk++; if (cursor_col !== 5'd0 || cursor_row !== 2'd0) $display("FAIL ff_cursor: got (%0d,%0d) want (0,0)", cursor_col, cursor_row); else n_pass++;
        read_screen();
        for (int i = 0; i < CELLS; i++) begin
            n_chk++; if (got[i] !== 8'h20) $display("FAIL ff_cell[%0d]: got %h want 20", i, got[i]); else n_pass++;
        end
    endtask

    task automatic test_random();
        int eb, n, r;
        logic [7:0] b;
        for (int k = 0; k < 90; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 55)      b = rand_glyph();
            else if (r < 67) b = 8'h0D;
            else if (r < 72) b = 8'h0A;
            else if (r < 84) b = 8'h08;
            else if (r < 92) begin
                b = 8'($urandom_range(0, 31));
                if (b == 8'h0C) b = 8'h00;
            end
            else if (r < 98) b = 8'h7F;
            else             b = 8'h0C;
            send_byte(b, eb);
            wait_idle(n);
            n_chk++; if (n != eb) $display("FAIL rand_busy[%0d] byte %h: got %0d cycles want %0d", k, b, n, eb); else n_pass++;
            n_chk++; if (cursor_col !== 5'(m_col) || cursor_row !== 2'(m_row)) $display("FAIL rand_cursor[%0d] byte %h: got (%0d,%0d) want (%0d,%0d)", k, b, cursor_col, cursor_row, m_col, m_row); else n_pass++;
        end
        read_screen();
        for (int i = 0; i < CELLS; i++) begin
            n_chk++; if (got[i] !== m_mem[i]) $display("FAIL rand_cell[%0d]: got %h want %h", i, got[i], m_mem[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_scroll();
        int eb, n;
        logic [7:0] v;
        send_byte(8'h0C, eb);
        wait_idle(n);
        send_byte(8'h5A, eb);
        send_byte(8'h0D, eb);
        send_byte(8'h59, eb);
        send_byte(8'h0D, eb);
        send_byte(8'h0D, eb);
        send_byte(8'h0D, eb);
        n_chk++; if (eb != SCROLL_CYC) $display("FAIL mid_model_scroll: got %0d want %0d", eb, SCROLL_CYC); else n_pass++;
        x = 10'(X0);
        y = 10'(Y0);
        repeat (60) @(posedge clk);
        #1;
        n_chk++; if (busy !== 1'b1) $display("FAIL mid_busy: got %b want 1", busy); else n_pass++;
        #2;
        reset_n = 1'b0;
        #1;
        n_chk++; if (ascii_code !== 8'h20) $display("FAIL async_ascii: got %h want 20", ascii_code); else n_pass++;
        n_chk++; if (cursor_col !== 5'd0 || cursor_row !== 2'd0) $display("FAIL async_cursor: got (%0d,%0d) want (0,0)", cursor_col, cursor_row); else n_pass++;
        n_chk++; if (wr_if.wr_ready !== 1'b0 || busy !== 1'b1) $display("FAIL async_ctrl: got ready %b busy %b want ready 0 busy 1", wr_if.wr_ready, busy); else n_pass++;
        wr_if.wr_valid = 1'b1;
        wr_if.wr_data  = 8'h42;
        @(posedge clk); #1;
        reset_n = 1'b1;
        model_reset();
        wait_idle(n);
        n_chk++; if (n != CELLS) $display("FAIL reclear_len: got %0d want %0d", n, CELLS); else n_pass++;
        @(posedge clk); #1;
        wr_if.wr_valid = 1'b0;
        eb = model_apply(8'h42);
        n_chk++; if (cursor_col !== 5'd1 || cursor_row !== 2'd0) $display("FAIL held_cursor: got (%0d,%0d) want (1,0)", cursor_col, cursor_row); else n_pass++;
        read_cell(0, v);
        n_chk++; if (v !== 8'h42) $display("FAIL held_cell0: got %h want 42", v); else n_pass++;
        read_screen();
        for (int i = 0; i < CELLS; i++) begin
            n_chk++; if (got[i] !== m_mem[i]) $display("FAIL reclear_cell[%0d]: got %h want %h", i, got[i], m_mem[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_single_char();
        test_wrap_cr_bs();
        test_scroll();
        test_thai_and_clear();
        test_random();
        test_reset_mid_scroll();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
